// File: rtl/ex_stage_pipe_pkg.sv
// ex_pkg: shared types and helpers for the execute stage (ex_stage_pipe).
package ex_pkg;

   // Widest immediate-extension result sext() can produce; callers slice it down.
   localparam int EX_SEXT_W = 128;

   typedef enum logic [3:0] {
      EX_ADD  = 4'd0,
      EX_SUB  = 4'd1,
      EX_AND  = 4'd2,
      EX_OR   = 4'd3,
      EX_XOR  = 4'd4,
      EX_NOR  = 4'd5,
      EX_SLT  = 4'd6,
      EX_SLTU = 4'd7,
      EX_SLL  = 4'd8,
      EX_SRL  = 4'd9,
      EX_SRA  = 4'd10,
      EX_LUI  = 4'd11,
      EX_MUL  = 4'd12
   } ex_op_t;

   typedef enum logic [1:0] {
      BR_NONE = 2'd0,
      BR_BEQ  = 2'd1,
      BR_BNE  = 2'd2,
      BR_BGTZ = 2'd3
   } ex_br_t;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_DONE = 2'd2
   } ex_mul_state_t;

   // Sign-extend the low immw bits of imm to EX_SEXT_W bits.
   function automatic logic [EX_SEXT_W-1:0] sext(input logic [EX_SEXT_W-1:0] imm,
                                                 input int immw);
      logic [EX_SEXT_W-1:0] r;
      r = imm;
      for (int i = 0; i < EX_SEXT_W; i++)
         if (i >= immw) r[i] = imm[immw-1];
      return r;
   endfunction

endpackage

// File: rtl/ex_stage_pipe_alu.sv
// ex_alu: combinational ALU for ex_stage_pipe. MUL is not handled here and
// yields result 0 with all flags 0.
// SUB carry is the carry-out of a + ~b + 1, i.e. 1 means "no borrow".
module ex_alu
   import ex_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int IMMW  = 16
) (
   input  ex_op_t             i_op,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   input  logic [IMMW-1:0]    i_imm,
   output logic [WIDTH-1:0]   o_res,
   output logic               o_carry,
   output logic               o_ovf,
   output logic               o_zero
);
   localparam int SHW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int LUI_SH = (WIDTH > IMMW) ? (WIDTH - IMMW) : 0;
   localparam int M      = WIDTH - 1;

   logic [WIDTH:0]     w_add;
   logic [WIDTH:0]     w_sub;
   logic [SHW-1:0]     w_sh;

   assign w_add = {1'b0, i_a} + {1'b0, i_b};
   assign w_sub = {1'b0, i_a} + {1'b0, ~i_b} + (WIDTH+1)'(1);
   assign w_sh  = i_b[SHW-1:0];

   // Result and arithmetic flags per opcode
   always_comb begin
      o_res   = '0;
      o_carry = 1'b0;
      o_ovf   = 1'b0;
      case (i_op)
         EX_ADD: begin
            o_res   = w_add[WIDTH-1:0];
            o_carry = w_add[WIDTH];
            o_ovf   = (i_a[M] == i_b[M]) && (w_add[M] != i_a[M]);
         end
         EX_SUB: begin
            o_res   = w_sub[WIDTH-1:0];
            o_carry = w_sub[WIDTH];
            o_ovf   = (i_a[M] != i_b[M]) && (w_sub[M] != i_a[M]);
         end
         EX_AND:  o_res = i_a & i_b;
         EX_OR:   o_res = i_a | i_b;
         EX_XOR:  o_res = i_a ^ i_b;
         EX_NOR:  o_res = ~(i_a | i_b);
         EX_SLT:  o_res = WIDTH'($signed(i_a) < $signed(i_b));
         EX_SLTU: o_res = WIDTH'(i_a < i_b);
         EX_SLL:  o_res = i_a << w_sh;
         EX_SRL:  o_res = i_a >> w_sh;
         EX_SRA:  o_res = $unsigned($signed(i_a) >>> w_sh);
         EX_LUI:  o_res = WIDTH'(i_imm) << LUI_SH;
         default: o_res = '0;
      endcase
   end

   assign o_zero = (i_op != EX_MUL) && (o_res == '0);

endmodule

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: execute stage with forwarding, load-use stall, registered
// branch resolution and the EX/MEM boundary register.
// Optional feature: define EX_MUL_EN for the iterative shift-add multiplier.
module ex_stage_pipe
   import ex_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int RAW   = 5,
   parameter int IMMW  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [IMMW-1:0]  imm,
   input  logic [RAW-1:0]   rs,
   input  logic [RAW-1:0]   rt,
   input  logic [RAW-1:0]   rd,
   input  logic [3:0]       alu_op,
   input  logic             alu_src,
   input  logic [1:0]       br_type,
   input  logic             reg_write,
   input  logic             mem_to_reg,
   input  logic             mem_write,
   input  logic [RAW-1:0]   wb_rd,
   input  logic             wb_we,
   input  logic [WIDTH-1:0] wb_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_result,
   output logic [WIDTH-1:0] out_store_data,
   output logic [RAW-1:0]   out_rd,
   output logic             out_reg_write,
   output logic             out_mem_to_reg,
   output logic             out_mem_write,
   output logic             out_carry,
   output logic             out_overflow,
   output logic             out_zero,
   output logic             out_br_taken
);
   // ---------------- operand selection ----------------
   logic [EX_SEXT_W-1:0] w_imm_full;
   logic                 w_unused_imm;
   logic [WIDTH-1:0]     w_imm_ext;
   logic                 w_fwd_ok;
   logic                 w_fa_ex, w_fa_wb, w_fb_ex, w_fb_wb;
   logic [WIDTH-1:0]     w_op_a, w_rt_val, w_op_b;

   assign w_imm_full   = sext(EX_SEXT_W'(imm), IMMW);
   assign w_imm_ext    = w_imm_full[WIDTH-1:0];
   assign w_unused_imm = &{1'b0, w_imm_full};

   // A load's EX/MEM value is an address, not data, so it never forwards.
   assign w_fwd_ok = out_valid & out_reg_write & ~out_mem_to_reg;
   assign w_fa_ex  = (rs != '0) & w_fwd_ok & (out_rd == rs);
   assign w_fa_wb  = (rs != '0) & wb_we & (wb_rd == rs);
   assign w_fb_ex  = (rt != '0) & w_fwd_ok & (out_rd == rt);
   assign w_fb_wb  = (rt != '0) & wb_we & (wb_rd == rt);

   // Forwarding muxes: EX/MEM beats MEM/WB beats the register file
   always_comb begin
      w_op_a = a;
      if (w_fa_ex)      w_op_a = out_result;
      else if (w_fa_wb) w_op_a = wb_data;
      w_rt_val = b;
      if (w_fb_ex)      w_rt_val = out_result;
      else if (w_fb_wb) w_rt_val = wb_data;
      w_op_b = alu_src ? w_imm_ext : w_rt_val;
   end

   // ---------------- hazard / handshake ----------------
   logic w_rt_used, w_load_use, w_take;
   logic w_mul_busy, w_mul_start, w_mul_fin;
   logic [WIDTH-1:0] w_mul_res, w_mul_sd;
   logic [RAW-1:0]   w_mul_rd;
   logic             w_mul_rw, w_mul_m2r, w_mul_mw;

   // rt is only a real source when it feeds the ALU or is the store value.
   assign w_rt_used  = ~alu_src | mem_write;
   assign w_load_use = out_valid & out_mem_to_reg & (out_rd != '0) &
                       ((out_rd == rs) | (w_rt_used & (out_rd == rt)));
   assign in_ready   = ~w_load_use & ~w_mul_busy;
   assign w_take     = in_valid & in_ready & ~flush;

   // ---------------- ALU and branch ----------------
   logic [WIDTH-1:0] w_alu_res;
   logic             w_alu_c, w_alu_v, w_alu_z, w_br;

   ex_alu #(.WIDTH(WIDTH), .IMMW(IMMW)) u_alu (
      .i_op    (ex_op_t'(alu_op)),
      .i_a     (w_op_a),
      .i_b     (w_op_b),
      .i_imm   (imm),
      .o_res   (w_alu_res),
      .o_carry (w_alu_c),
      .o_ovf   (w_alu_v),
      .o_zero  (w_alu_z)
   );

   // Branch condition on the forwarded operands
   always_comb begin
      w_br = 1'b0;
      case (ex_br_t'(br_type))
         BR_BEQ:  w_br = (w_op_a == w_op_b);
         BR_BNE:  w_br = (w_op_a != w_op_b);
         BR_BGTZ: w_br = ($signed(w_op_a) > $signed(WIDTH'(0)));
         default: w_br = 1'b0;
      endcase
   end

   // ---------------- multiplier ----------------
`ifdef EX_MUL_EN
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   ex_mul_state_t    r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_acc, r_mcand, r_mplr, r_sd;
   logic [RAW-1:0]   r_rd;
   logic             r_rw, r_m2r, r_mw;
   logic [WIDTH-1:0] w_acc_step;
   logic             w_mul_last;

   assign w_acc_step  = r_acc + (r_mplr[0] ? r_mcand : '0);
   assign w_mul_start = w_take & (ex_op_t'(alu_op) == EX_MUL);
   assign w_mul_busy  = (r_state == MUL_BUSY);
   assign w_mul_last  = w_mul_busy & (r_cnt == CW'(WIDTH-1));
   assign w_mul_fin   = w_mul_last & ~flush;

   // Multiply FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= MUL_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state: DONE is the single cycle the product sits in the slot
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         MUL_IDLE, MUL_DONE: w_state_nxt = w_mul_start ? MUL_BUSY : MUL_IDLE;
         MUL_BUSY: begin
            if (flush)           w_state_nxt = MUL_IDLE;
            else if (w_mul_last) w_state_nxt = MUL_DONE;
         end
         default: w_state_nxt = MUL_IDLE;
      endcase
   end

   // Operand latch at acceptance, one shift-add step per BUSY cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_acc   <= '0;
         r_mcand <= '0;
         r_mplr  <= '0;
         r_sd    <= '0;
         r_rd    <= '0;
         r_rw    <= 1'b0;
         r_m2r   <= 1'b0;
         r_mw    <= 1'b0;
      end else if (w_mul_start) begin
         r_cnt   <= '0;
         r_acc   <= '0;
         r_mcand <= w_op_a;
         r_mplr  <= w_op_b;
         r_sd    <= w_rt_val;
         r_rd    <= rd;
         r_rw    <= reg_write;
         r_m2r   <= mem_to_reg;
         r_mw    <= mem_write;
      end else if (w_mul_busy) begin
         r_cnt   <= r_cnt + CW'(1);
         r_acc   <= w_acc_step;
         r_mcand <= r_mcand << 1;
         r_mplr  <= r_mplr >> 1;
      end
   end

   assign w_mul_res = w_acc_step;
   assign w_mul_sd  = r_sd;
   assign w_mul_rd  = r_rd;
   assign w_mul_rw  = r_rw;
   assign w_mul_m2r = r_m2r;
   assign w_mul_mw  = r_mw;
`else
   assign w_mul_busy  = 1'b0;
   assign w_mul_start = 1'b0;
   assign w_mul_fin   = 1'b0;
   assign w_mul_res   = '0;
   assign w_mul_sd    = '0;
   assign w_mul_rd    = '0;
   assign w_mul_rw    = 1'b0;
   assign w_mul_m2r   = 1'b0;
   assign w_mul_mw    = 1'b0;
`endif

   // ---------------- EX/MEM slot ----------------
   // Control bits default to a bubble; data fields only move on a real load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid      <= 1'b0;
         out_result     <= '0;
         out_store_data <= '0;
         out_rd         <= '0;
         out_reg_write  <= 1'b0;
         out_mem_to_reg <= 1'b0;
         out_mem_write  <= 1'b0;
         out_carry      <= 1'b0;
         out_overflow   <= 1'b0;
         out_zero       <= 1'b0;
         out_br_taken   <= 1'b0;
      end else begin
         out_valid      <= 1'b0;
         out_reg_write  <= 1'b0;
         out_mem_to_reg <= 1'b0;
         out_mem_write  <= 1'b0;
         out_carry      <= 1'b0;
         out_overflow   <= 1'b0;
         out_zero       <= 1'b0;
         out_br_taken   <= 1'b0;
         if (w_mul_fin) begin
            out_valid      <= 1'b1;
            out_result     <= w_mul_res;
            out_store_data <= w_mul_sd;
            out_rd         <= w_mul_rd;
            out_reg_write  <= w_mul_rw;
            out_mem_to_reg <= w_mul_m2r;
            out_mem_write  <= w_mul_mw;
            out_zero       <= (w_mul_res == '0);
         end else if (w_take & ~w_mul_start) begin
            out_valid      <= 1'b1;
            out_result     <= w_alu_res;
            out_store_data <= w_rt_val;
            out_rd         <= rd;
            out_reg_write  <= reg_write;
            out_mem_to_reg <= mem_to_reg;
            out_mem_write  <= mem_write;
            out_carry      <= w_alu_c;
            out_overflow   <= w_alu_v;
            out_zero       <= w_alu_z;
            out_br_taken   <= w_br;
         end
      end
   end

endmodule

// File: doc/ex_stage_pipe.md
# ex_stage_pipe

Parametrised execute stage for the five-stage pipeline. Sits between ID and MEM and owns the ID/EX→EX/MEM boundary register. Generalises the fixed 32-bit EX stage with:
- configurable datapath width;
- two-level operand forwarding (EX/MEM and MEM/WB);
- internal load-use stall with bubble insertion;
- registered branch resolution;
- valid/ready handshake with flush;
- an optional multi-cycle multiplier.

## Interface
- `WIDTH`, 32, datapath width (≥8)
- `RAW`, 5, register address width
- `IMMW`, 16, immediate width; sign-extended to WIDTH
- `clk` in 1 — rising-edge clock
- `rst_n` in 1 — asynchronous, active-low reset
- `in_valid` in 1 — ID presents an instruction
- `in_ready` out 1 — EX accepts this cycle; 0 = stall ID
- `flush` in 1 — squash the instruction being accepted and abort any multiply
- `a`, `b` in WIDTH — register-file operands
- `imm` in IMMW — immediate
- `rs`, `rt`, `rd` in RAW — source and destination addresses
- `alu_op` in 4 — `ex_op_t`
- `alu_src` in 1 — 1 = B operand is sign-extended imm
- `br_type` in 2 — `ex_br_t`: NONE, BEQ, BNE, BGTZ
- `reg_write`, `mem_to_reg`, `mem_write` in 1 — control from ID
- `wb_rd` in RAW; `wb_we` in 1; `wb_data` in WIDTH — MEM/WB forwarding source
- `out_valid` out 1 — EX/MEM slot holds a live instruction
- `out_result`, `out_store_data` out WIDTH
- `out_rd` out RAW
- `out_reg_write`, `out_mem_to_reg`, `out_mem_write` out 1
- `out_carry`, `out_overflow`, `out_zero` out 1
- `out_br_taken` out 1

## Operation
Forwarding, evaluated per operand:
- Address 0 is never forwarded.
- EX/MEM is the first choice. It is used when `out_valid & out_reg_write & !out_mem_to_reg` and `out_rd` matches.
- WB is the second choice, used when `wb_we` and `wb_rd` match.
- Otherwise the register-file value is used.
- `out_store_data` is always the forwarded rt value, regardless of `alu_src`.

Load-use stall:
- Condition: `out_valid & out_mem_to_reg & out_rd≠0`, and `out_rd` matches either `rs` or `rt`. `rt` counts only when `alu_src=0` or `mem_write=1`.
- Effect: `in_ready=0` and a bubble is clocked in (`out_valid=0`).
- Next cycle the load is in WB and its value is forwarded from WB.

ALU ops:
- ADD and SUB produce carry and two's-complement overflow.
- AND, OR, XOR, NOR.
- SLT (signed) and SLTU produce 0 or 1.
- SLL, SRL, SRA use B[$clog2(WIDTH)-1:0] as the shift amount.
- LUI produces imm << (WIDTH-IMMW).
- MUL is described under Configuration.
- `out_zero` is set when the result is all zeros.
- For ops other than ADD/SUB, carry and overflow are 0.

Branch resolution:
- BEQ: taken when opA==opB.
- BNE: taken when opA≠opB.
- BGTZ: taken when opA is signed and >0.
- `out_br_taken` is registered alongside the result. It is 0 for NONE and for bubbles.

Handshake:
- An instruction is accepted when `in_valid & in_ready`.
- On acceptance with `flush=0`, the EX/MEM slot loads the instruction and `out_valid=1`.
- When not accepted, or when `flush=1`, the slot loads a bubble. All `out_*` control bits are 0 and the data fields hold their previous values.

Reset (asynchronous): all `out_*` are 0, the multiply FSM is IDLE, and `in_ready=1`.

## Timing
- Single-cycle ops: accepted at edge N, results visible after edge N+1. Throughput is one per cycle.
- Load-use: exactly one bubble cycle.
- Forwarding is a combinational path from `out_*` and `wb_*` into the ALU in the same cycle.
- `flush` together with a load-use stall: the bubble is inserted and `in_ready` stays 0.
- Reset asserted mid-multiply: FSM returns to IDLE and no result is emitted.

## Configuration
`EX_MUL_EN` defined:
- MUL is an iterative shift-add multiply producing the low WIDTH bits.
- FSM: IDLE→BUSY on acceptance; operands are latched.
- BUSY runs WIDTH iterations while `in_ready=0` and bubbles are emitted.
- DONE lasts one cycle: the result is written to the slot with `out_valid=1`, then the FSM returns to IDLE.
- Total latency is WIDTH+1 cycles.
- `flush` in BUSY returns the FSM to IDLE with no output.
- Forwarding sources are re-evaluated only at acceptance.

`EX_MUL_EN` undefined:
- MUL yields result 0 and flags 0 in one cycle.
- The FSM and counter are not synthesised.

## Structure
- Package `ex_pkg` holds:
  - `ex_op_t` (4-bit enum);
  - `ex_br_t`;
  - `ex_mul_state_t`;
  - the function `sext(imm)`.
- Sub-module `ex_alu`: combinational, parametrised by WIDTH, and provides op, flags and set.
- The multiplier FSM and the forwarding muxes stay in `ex_stage_pipe`.

## Test plan
- ADD 0x7FFFFFFF+1 (WIDTH=32) → result 0x80000000, overflow 1, carry 0, zero 0. SUB 5−5 → zero 1.
- Back-to-back ADD r3=r1+r2 then SUB r4=r3−r1 with a stale r3 in the register file → second instruction uses the EX/MEM value. Same dependency two instructions apart → uses `wb_data`.
- LW r5, then ADD r6=r5+r5 → `in_ready=0` for one cycle and one bubble (`out_valid=0`). ADD then uses `wb_data`=0x1234 and the result is 0x2468.
- BEQ with equal forwarded operands → `out_br_taken=1`. BGTZ with opA=0x80000000 → 0. BNE with `flush=1` on acceptance → `out_valid=0`, `out_br_taken=0`.
- `EX_MUL_EN`, MUL 7×6 → `in_ready` low for 32 cycles, then result 42. A second MUL flushed mid-BUSY → no output and `in_ready=1` the next cycle.
- `rst_n` pulsed low asynchronously during traffic → all `out_*` are 0 immediately.
